load_hazard_scoreboard: RTL and testbench
=========================================

// Module: load_hazard_scoreboard
// PURPOSE
//  Parametrised load-use hazard unit; successor to the single-cycle load-use stall check.
//  Sits beside the IF/ID and ID/EX registers. Tracks in-flight loads per register file in a countdown
//  scoreboard, so loads returning LOAD_LAT cycles after EX stall consumers exactly until forwardable.
//  Drives pc_write / if_id_write / control_sel (bubble insert) for the 5-stage RISC-V core.
// PARAMETERS
//  NREG     32  registers per file (power of 2)
//  RBITS    5   register index width, = log2(NREG)
//  LOAD_LAT 1   cycles from load leaving EX until its data is forwardable (>=1); 1 = classic one-bubble
//  CW       $clog2(LOAD_LAT+1)  counter width (localparam, not overridable)
// PORTS
//  clk                 in  1      core clock
//  rst_n               in  1      asynchronous active-low reset
//  id_ex_valid         in  1      ID/EX holds a real instruction (0 = bubble)
//  id_ex_memread       in  1      ID/EX instruction is a load
//  id_ex_rd_sel        in  1      rd file: 0 = integer, 1 = float
//  id_ex_register_rd   in  RBITS  load destination
//  ex_flush            in  1      branch mispredict: kill ID/EX contents this cycle
//  mem_wait            in  1      data memory busy: whole pipeline frozen this cycle
//  if_id_rs1_sel/rs2_sel    in  1      source file selects
//  if_id_rs1_used/rs2_used  in  1      source actually read by the IF/ID instruction
//  if_id_register_rs1/rs2   in  RBITS  source indices
//  pc_write            out 1      1 = PC may advance
//  if_id_write         out 1      1 = IF/ID may load
//  control_sel         out 1      1 = pass decoded controls, 0 = inject bubble into ID/EX
//  stall               out 1      = ~pc_write, for debug/perf
// BEHAVIOUR
//  - Scoreboard: 2*NREG counters cnt[sel][reg] of CW bits; entry busy when cnt != 0.
//  - Integer reg 0 never tracked and never matches; float reg 0 is a normal register.
//  - Issue event (posedge): id_ex_valid & id_ex_memread & ~ex_flush & ~mem_wait & ~(sel==0 & rd==0)
//    -> cnt[sel][rd] <= LOAD_LAT-1. For LOAD_LAT==1 the scoreboard stays all-zero.
//  - Decrement: every other busy entry decrements by 1 per cycle when ~mem_wait; holds when mem_wait.
//  - Issue to an entry that is already busy overwrites it (issue wins over decrement).
//  - Hazard, combinational, per source s in {rs1,rs2}, with s_used=1:
//      direct: id_ex_valid & id_ex_memread & ~ex_flush & sel/idx match ID/EX rd (rd!=0 for int file)
//      pending: cnt[s_sel][s_idx] != 0
//    stall = OR over sources of (direct | pending). Unused sources never stall.
//  - pc_write = if_id_write = control_sel = ~stall. Outputs have zero latency from inputs/state.
//  - ex_flush also clears nothing already in the scoreboard (committed loads still return).
//  - mem_wait: outputs still computed normally; core gates them with its own freeze.
//  - Reset (async, rst_n=0): all counters 0; pc_write=if_id_write=control_sel=1, stall=0 while asserted
//    (hazard logic forced off). Reset mid-operation discards all pending loads immediately.
//  - Stall length for a dependent instruction right behind a load: exactly LOAD_LAT cycles.
// CONFIGURATION
//  HAZ_STALL_CNT_EN defined: extra port stall_cycles out 16, counts cycles with stall=1 & ~mem_wait,
//    saturates at 16'hFFFF, reset to 0 by rst_n. Undefined: port and counter absent, no other change.
// TESTING
//  1 LOAD_LAT=1: lw x5 in ID/EX, add uses rs1=x5 in IF/ID -> stall=1 one cycle, then 0; control_sel=0 that cycle.
//  2 LOAD_LAT=3: lw x7 then dependent use rs2=x7 -> stall high exactly 3 cycles; independent rs x8 -> no stall.
//  3 Int rd=x0 load + use x0 -> no stall; float flw f0 + fadd using f0 (sel=1) -> stall.
//  4 Load in ID/EX with ex_flush=1 and matching consumer -> stall=0, no scoreboard entry created.
//  5 LOAD_LAT=3, entry x9 cnt=2, mem_wait=1 for 4 cycles -> cnt holds at 2, stall stays 1, then 2 more cycles.
//  6 rst_n low while cnt[0][5]=2 -> stall=0 asynchronously; after release use of x5 -> no stall;
//    with HAZ_STALL_CNT_EN, stall_cycles=0 after reset and counts 3 after test 2.

Source files
------------

// File: rtl/load_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// load_hazard_scoreboard
//
// Load-use hazard unit for the 5-stage RISC-V core. It sits beside the IF/ID
// and ID/EX registers and keeps one countdown counter per architectural
// register, per register file (integer and float). A load leaving EX loads
// its counter with LOAD_LAT-1. The counter then counts down once per
// unfrozen cycle. Any consumer in IF/ID that reads a register still in
// flight is stalled until the load data can be forwarded. With LOAD_LAT=1
// this reduces to the classic one-bubble load-use stall.
//
// Parameters
//   NREG      registers per file (power of 2)
//   RBITS     register index width (log2(NREG))
//   LOAD_LAT  cycles from a load leaving EX until its data is forwardable (>=1)
//
// Ports
//   clk                  in   core clock
//   rst_n                in   asynchronous active-low reset
//   id_ex_valid          in   ID/EX holds a real instruction (0 = bubble)
//   id_ex_memread        in   ID/EX instruction is a load
//   id_ex_rd_sel         in   load destination file: 0 = integer, 1 = float
//   id_ex_register_rd    in   load destination index
//   ex_flush             in   branch mispredict: ID/EX contents killed this cycle
//   mem_wait             in   data memory busy: whole pipeline frozen this cycle
//   if_id_rs1_sel/_rs2_sel           in  source file selects
//   if_id_rs1_used/_rs2_used         in  source actually read by IF/ID instruction
//   if_id_register_rs1/_rs2          in  source indices
//   pc_write             out  1 = PC may advance
//   if_id_write          out  1 = IF/ID may load
//   control_sel          out  1 = pass decoded controls, 0 = inject bubble
//   stall                out  ~pc_write, for debug/perf
//   stall_cycles         out  (HAZ_STALL_CNT_EN only) saturating count of
//                             cycles with stall=1 and mem_wait=0
//
// Build option
//   HAZ_STALL_CNT_EN  define to add the stall_cycles performance counter.
// -----------------------------------------------------------------------------
module load_hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int RBITS    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_valid,
  input  logic             id_ex_memread,
  input  logic             id_ex_rd_sel,
  input  logic [RBITS-1:0] id_ex_register_rd,
  input  logic             ex_flush,
  input  logic             mem_wait,
  input  logic             if_id_rs1_sel,
  input  logic             if_id_rs2_sel,
  input  logic             if_id_rs1_used,
  input  logic             if_id_rs2_used,
  input  logic [RBITS-1:0] if_id_register_rs1,
  input  logic [RBITS-1:0] if_id_register_rs2,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             control_sel,
  output logic             stall
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] ISSUE_VAL = CW'(LOAD_LAT - 1);

  // Scoreboard: [file][register] remaining cycles until forwardable.
  logic [CW-1:0]          r_cnt [2][NREG];

  logic                   w_rd_tracked;
  logic                   w_ex_load;
  logic                   w_issue;
  logic [1:0][NREG-1:0]   w_issue_dec;
  logic                   w_pend_rs1;
  logic                   w_pend_rs2;
  logic                   w_haz_rs1;
  logic                   w_haz_rs2;
  logic                   w_hazard;

  // Per-source hazard: a used source conflicts either with the load that is
  // in EX right now, or with a load that already left EX and is still
  // counting down.
  function automatic logic src_hazard(
    input logic             used,
    input logic             sel,
    input logic [RBITS-1:0] idx,
    input logic             ex_load,
    input logic             ex_sel,
    input logic [RBITS-1:0] ex_rd,
    input logic             pend
  );
    logic direct;
    direct = ex_load & (sel == ex_sel) & (idx == ex_rd);
    return used & (direct | pend);
  endfunction

  // Saturating 16-bit increment for the performance counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // Integer x0 is hard-wired zero, so it is never a load target worth
  // tracking. Float f0 is an ordinary register.
  always_comb begin
    w_rd_tracked = id_ex_rd_sel | (id_ex_register_rd != '0);
    w_ex_load    = id_ex_valid & id_ex_memread & ~ex_flush & w_rd_tracked;
    w_issue      = w_ex_load & ~mem_wait;
  end

  always_comb begin
    w_issue_dec = '0;
    if (w_issue) begin
      w_issue_dec[id_ex_rd_sel][id_ex_register_rd] = 1'b1;
    end
  end

  // The x0 mask keeps a source of integer x0 from ever matching, regardless
  // of what the scoreboard holds.
  always_comb begin
    w_pend_rs1 = (r_cnt[if_id_rs1_sel][if_id_register_rs1] != '0) &
                 (if_id_rs1_sel | (if_id_register_rs1 != '0));
    w_pend_rs2 = (r_cnt[if_id_rs2_sel][if_id_register_rs2] != '0) &
                 (if_id_rs2_sel | (if_id_register_rs2 != '0));
    w_haz_rs1  = src_hazard(if_id_rs1_used, if_id_rs1_sel, if_id_register_rs1,
                            w_ex_load, id_ex_rd_sel, id_ex_register_rd, w_pend_rs1);
    w_haz_rs2  = src_hazard(if_id_rs2_used, if_id_rs2_sel, if_id_register_rs2,
                            w_ex_load, id_ex_rd_sel, id_ex_register_rd, w_pend_rs2);
    w_hazard   = w_haz_rs1 | w_haz_rs2;
  end

  // Countdown update. A new issue overwrites whatever the entry held. Other
  // busy entries tick down only while the pipeline is moving, because a
  // frozen pipeline also freezes the load in MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < NREG; r++) begin
          r_cnt[f][r] <= '0;
        end
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < NREG; r++) begin
          if (w_issue_dec[f][r]) begin
            r_cnt[f][r] <= ISSUE_VAL;
          end else if (!mem_wait && (r_cnt[f][r] != '0)) begin
            r_cnt[f][r] <= r_cnt[f][r] - CW'(1);
          end
        end
      end
    end
  end

  // Reset gates the hazard off combinationally, so the core sees "advance"
  // for as long as rst_n is low, not only after the next edge.
  always_comb begin
    stall       = w_hazard & rst_n;
    pc_write    = ~stall;
    if_id_write = ~stall;
    control_sel = ~stall;
  end

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (stall && !mem_wait) begin
      r_stall_cycles <= sat_inc16(r_stall_cycles);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
module tb_load_hazard_scoreboard;

  typedef struct {
    logic       v;
    logic       mr;
    logic       rsel;
    logic [4:0] rd;
    logic       fl;
    logic       mw;
    logic       s1sel;
    logic       s1u;
    logic [4:0] s1;
    logic       s2sel;
    logic       s2u;
    logic [4:0] s2;
    logic       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_ex_valid, id_ex_memread, id_ex_rd_sel, ex_flush, mem_wait;
  logic [4:0] id_ex_register_rd;
  logic       if_id_rs1_sel, if_id_rs2_sel, if_id_rs1_used, if_id_rs2_used;
  logic [4:0] if_id_register_rs1, if_id_register_rs2;

  logic pc1, ifw1, cs1, st1;
  logic pc3, ifw3, cs3, st3;
`ifdef HAZ_STALL_CNT_EN
  logic [15:0] sc1, sc3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_hazard_scoreboard #(.NREG(32), .RBITS(5), .LOAD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_valid(id_ex_valid), .id_ex_memread(id_ex_memread),
    .id_ex_rd_sel(id_ex_rd_sel), .id_ex_register_rd(id_ex_register_rd),
    .ex_flush(ex_flush), .mem_wait(mem_wait),
    .if_id_rs1_sel(if_id_rs1_sel), .if_id_rs2_sel(if_id_rs2_sel),
    .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
    .if_id_register_rs1(if_id_register_rs1), .if_id_register_rs2(if_id_register_rs2),
    .pc_write(pc1), .if_id_write(ifw1), .control_sel(cs1), .stall(st1)
`ifdef HAZ_STALL_CNT_EN
    , .stall_cycles(sc1)
`endif
  );

  load_hazard_scoreboard #(.NREG(32), .RBITS(5), .LOAD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_valid(id_ex_valid), .id_ex_memread(id_ex_memread),
    .id_ex_rd_sel(id_ex_rd_sel), .id_ex_register_rd(id_ex_register_rd),
    .ex_flush(ex_flush), .mem_wait(mem_wait),
    .if_id_rs1_sel(if_id_rs1_sel), .if_id_rs2_sel(if_id_rs2_sel),
    .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
    .if_id_register_rs1(if_id_register_rs1), .if_id_register_rs2(if_id_register_rs2),
    .pc_write(pc3), .if_id_write(ifw3), .control_sel(cs3), .stall(st3)
`ifdef HAZ_STALL_CNT_EN
    , .stall_cycles(sc3)
`endif
  );

  function automatic vec_t mk(input int v, input int mr, input int rsel, input int rd,
                              input int fl, input int mw, input int s1sel, input int s1u,
                              input int s1, input int s2sel, input int s2u, input int s2,
                              input int e);
    vec_t t;
    t.v = v[0];         t.mr = mr[0];       t.rsel = rsel[0];  t.rd = rd[4:0];
    t.fl = fl[0];       t.mw = mw[0];
    t.s1sel = s1sel[0]; t.s1u = s1u[0];     t.s1 = s1[4:0];
    t.s2sel = s2sel[0]; t.s2u = s2u[0];     t.s2 = s2[4:0];
    t.e = e[0];
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_ex_valid        = t.v;
    id_ex_memread      = t.mr;
    id_ex_rd_sel       = t.rsel;
    id_ex_register_rd  = t.rd;
    ex_flush           = t.fl;
    mem_wait           = t.mw;
    if_id_rs1_sel      = t.s1sel;
    if_id_rs1_used     = t.s1u;
    if_id_register_rs1 = t.s1;
    if_id_rs2_sel      = t.s2sel;
    if_id_rs2_used     = t.s2u;
    if_id_register_rs2 = t.s2;
  endtask

  // Expected {stall, pc_write, if_id_write, control_sel} for a stall value.
  function automatic logic [3:0] outs_for(input logic s);
    return {s, ~s, ~s, ~s};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample both instances' outputs against their expected stall values.
  task automatic check_both(input string name, input logic e1, input logic e3);
    check($sformatf("%s/lat1", name), {12'd0, st1, pc1, ifw1, cs1}, {12'd0, outs_for(e1)});
    check($sformatf("%s/lat3", name), {12'd0, st3, pc3, ifw3, cs3}, {12'd0, outs_for(e3)});
  endtask

  // One pipeline cycle: drive after the falling edge, sample 1ns later.
  task automatic step(input string name, input vec_t t, input logic e1, input logic e3);
    @(negedge clk);
    drive(t);
    #1;
    check_both(name, e1, e3);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];
  vec_t idle;
  vec_t use5, use7, use9, usef0, use0;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);

    //             v mr rs rd fl mw s1s s1u s1 s2s s2u s2 e
    tbl[0]  = mk(1,1, 0, 5, 0,0, 0,  1,  5, 0,  0,  0, 1); // lw x5, use rs1 x5
    tbl[1]  = mk(1,1, 0, 5, 0,0, 0,  1,  6, 0,  1,  7, 0); // independent sources
    tbl[2]  = mk(1,1, 0, 7, 0,0, 0,  0,  0, 0,  1,  7, 1); // lw x7, use rs2 x7
    tbl[3]  = mk(1,1, 0, 7, 0,0, 0,  0,  7, 0,  0,  7, 0); // match but unused
    tbl[4]  = mk(1,1, 0, 0, 0,0, 0,  1,  0, 0,  1,  0, 0); // int x0 never matches
    tbl[5]  = mk(1,1, 1, 0, 0,0, 1,  1,  0, 0,  0,  0, 1); // flw f0, use f0
    tbl[6]  = mk(1,1, 1, 5, 0,0, 0,  1,  5, 0,  0,  0, 0); // flw f5, use int x5
    tbl[7]  = mk(1,1, 0, 5, 1,0, 0,  1,  5, 0,  0,  0, 0); // flushed load
    tbl[8]  = mk(0,1, 0, 5, 0,0, 0,  1,  5, 0,  0,  0, 0); // bubble in ID/EX
    tbl[9]  = mk(1,0, 0, 5, 0,0, 0,  1,  5, 0,  0,  0, 0); // ALU op, not load
    tbl[10] = mk(1,1, 0, 5, 0,1, 0,  1,  5, 0,  0,  0, 1); // mem_wait: still stalls
    tbl[11] = mk(1,1, 0,31, 0,0, 1,  1, 31, 0,  1, 31, 1); // x31 via rs2
    tbl[12] = mk(1,1, 0, 5, 0,0, 0,  1,  4, 1,  1,  5, 0); // rs2 is f5, load is x5

    use5  = mk(0,0,0,0,0,0, 0,1, 5, 0,0,0, 0);
    use7  = mk(0,0,0,0,0,0, 0,0, 0, 0,1,7, 0);
    use9  = mk(0,0,0,0,0,1, 0,1, 9, 0,0,0, 0);
    usef0 = mk(0,0,0,0,0,0, 1,1, 0, 0,0,0, 0);
    use0  = mk(0,0,0,0,0,0, 0,1, 0, 0,1,0, 0);

    // Reset asserted with a hazard on the inputs: hazard logic is forced off.
    rst_n = 1'b0;
    drive(tbl[0]);
    #1;
    check_both("reset_forced", 1'b0, 1'b0);
`ifdef HAZ_STALL_CNT_EN
    check("reset_cnt1", sc1, 16'd0);
    check("reset_cnt3", sc3, 16'd0);
`endif
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;

    // Combinational vectors; inputs return to idle before each rising edge
    // so the scoreboards stay empty.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_both($sformatf("vec%0d", i), tbl[i].e, tbl[i].e);
      #1;
      drive(idle);
    end

    // Load-use x5: one bubble at LOAD_LAT=1, three at LOAD_LAT=3.
    step("ld5_c0", mk(1,1,0,5,0,0, 0,1,5, 0,0,0, 0), 1'b1, 1'b1);
    step("ld5_c1", use5, 1'b0, 1'b1);
    step("ld5_c2", use5, 1'b0, 1'b1);
    step("ld5_c3", use5, 1'b0, 1'b0);

    // Flushed load leaves no scoreboard entry.
    step("flush_c0", mk(1,1,0,5,1,0, 0,1,5, 0,0,0, 0), 1'b0, 1'b0);
    step("flush_c1", use5, 1'b0, 1'b0);
    step("flush_c2", use5, 1'b0, 1'b0);

    // Integer x0 load creates no entry; float f0 load does.
    step("x0_c0", mk(1,1,0,0,0,0, 0,1,0, 0,1,0, 0), 1'b0, 1'b0);
    step("x0_c1", use0, 1'b0, 1'b0);
    step("f0_c0", mk(1,1,1,0,0,0, 1,1,0, 0,0,0, 0), 1'b1, 1'b1);
    step("f0_c1", usef0, 1'b0, 1'b1);
    step("f0_c2", usef0, 1'b0, 1'b1);
    step("f0_c3", usef0, 1'b0, 1'b0);

    // Dependent rs2=x7 behind lw x7; then an independent source.
    reset_pulse();
    step("ld7_c0", mk(1,1,0,7,0,0, 0,0,0, 0,1,7, 0), 1'b1, 1'b1);
    step("ld7_c1", use7, 1'b0, 1'b1);
    step("ld7_c2", use7, 1'b0, 1'b1);
    step("ld7_c3", use7, 1'b0, 1'b0);
`ifdef HAZ_STALL_CNT_EN
    check("ld7_cnt1", sc1, 16'd1);
    check("ld7_cnt3", sc3, 16'd3);
`endif
    step("indep_c0", mk(1,1,0,7,0,0, 0,1,8, 0,0,7, 0), 1'b0, 1'b0);
    step("indep_c1", mk(0,0,0,0,0,0, 0,1,8, 0,0,0, 0), 1'b0, 1'b0);
    step("drain_c0", idle, 1'b0, 1'b0);
    step("drain_c1", idle, 1'b0, 1'b0);

    // mem_wait freezes the countdown of x9 for four cycles.
    step("mw_c0", mk(1,1,0,9,0,0, 0,1,9, 0,0,0, 0), 1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step($sformatf("mw_hold%0d", c), use9, 1'b0, 1'b1);
    end
    use9.mw = 1'b0;
    step("mw_run1", use9, 1'b0, 1'b1);
    step("mw_run2", use9, 1'b0, 1'b1);
    step("mw_done", use9, 1'b0, 1'b0);
`ifdef HAZ_STALL_CNT_EN
    check("mw_cnt1", sc1, 16'd2);
    check("mw_cnt3", sc3, 16'd6);
`endif

    // Reset mid-countdown discards the pending x5 load at once.
    step("rst_c0", mk(1,1,0,5,0,0, 0,1,5, 0,0,0, 0), 1'b1, 1'b1);
    step("rst_c1", use5, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_both("rst_async", 1'b0, 1'b0);
`ifdef HAZ_STALL_CNT_EN
    check("rst_cnt1", sc1, 16'd0);
    check("rst_cnt3", sc3, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_both("rst_rel0", 1'b0, 1'b0);
    step("rst_rel1", use5, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
